// File: rtl/uartrx.sv
`default_nettype none
// ============================================================================
// Module   : uartrx
// Purpose  : UART receiver, 16x oversampling, LSB-first, valid/ready output
//            with parity, framing and overrun status. Optional break
//            detection is compiled in when UARTRX_BREAK_DETECT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module uartrx #(
    parameter int I_CLK_FRQ = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int PARITY    = 0,
    parameter int FRAME     = 8,
    parameter int STOP      = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx,
    output logic [FRAME-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_parity_err,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic             o_break,
    output logic             o_busy
);

    localparam int DIV_CALC = (I_CLK_FRQ + 8 * BAUD) / (16 * BAUD);
    localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
`ifdef UARTRX_BREAK_DETECT_EN
        , S_BRK = 3'd5
`endif
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rxs_q, rxs_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [3:0]         tcnt_q, tcnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic [FRAME-1:0]   shreg_q, shreg_d;
    logic               rx_perr_q, rx_perr_d;
    logic               rx_ferr_q, rx_ferr_d;
    logic [FRAME-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               overrun_q, overrun_d;
`ifdef UARTRX_BREAK_DETECT_EN
    logic               par_bit_q, par_bit_d;
    logic               break_q, break_d;
`endif

    logic tick;
    logic sample;
    logic done;
    logic done_ferr;
    logic is_break;

    assign tick   = (div_cnt_q == DIV_LAST);
    assign sample = tick && (tcnt_q == 4'd7);

    always_comb begin
        rx_meta_d  = i_rx;
        rxs_d      = rx_meta_q;
        state_d    = state_q;
        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        tcnt_d     = tick ? tcnt_q + 4'd1 : tcnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        overrun_d  = 1'b0;
        done       = 1'b0;
        done_ferr  = rx_ferr_q | ~rxs_q;
`ifdef UARTRX_BREAK_DETECT_EN
        par_bit_d  = par_bit_q;
        break_d    = 1'b0;
        is_break   = (shreg_q == '0) && ((PARITY == 0) || !par_bit_q) && done_ferr;
`else
        is_break   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // Re-phase the divider and tick counter to the start edge.
                if (!rxs_q) begin
                    state_d   = S_START;
                    div_cnt_d = '0;
                    tcnt_d    = '0;
                end
            end
            S_START: begin
                if (sample) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        rx_perr_d = 1'b0;
                        rx_ferr_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shreg_d   = {rxs_q, shreg_q[FRAME-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(FRAME - 1)) begin
                        state_d    = (PARITY != 0) ? S_PAR : S_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            S_PAR: begin
                if (sample) begin
                    rx_perr_d  = rxs_q ^ (^shreg_q);
`ifdef UARTRX_BREAK_DETECT_EN
                    par_bit_d  = rxs_q;
`endif
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (sample) begin
                    rx_ferr_d = done_ferr;
                    if (stop_cnt_q == 1'(STOP - 1)) begin
                        // Leave without waiting for the bit end so a new start is caught.
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UARTRX_BREAK_DETECT_EN
            S_BRK: begin
                if (tick) begin
                    if (!rxs_q) begin
                        tcnt_d = '0;
                    end else if (tcnt_q == 4'd15) begin
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef UARTRX_BREAK_DETECT_EN
        if (done && is_break) begin
            break_d = 1'b1;
            state_d = S_BRK;
            tcnt_d  = '0;
        end
`endif

        if (done && !is_break) begin
            if (!valid_q || i_ready) begin
                data_d  = shreg_q;
                perr_d  = rx_perr_q;
                ferr_d  = done_ferr;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            div_cnt_q  <= '0;
            tcnt_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UARTRX_BREAK_DETECT_EN
            par_bit_q  <= 1'b0;
            break_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rxs_q      <= rxs_d;
            div_cnt_q  <= div_cnt_d;
            tcnt_q     <= tcnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
`ifdef UARTRX_BREAK_DETECT_EN
            par_bit_q  <= par_bit_d;
            break_q    <= break_d;
`endif
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = (state_q != S_IDLE);
`ifdef UARTRX_BREAK_DETECT_EN
    assign o_break      = break_q;
`else
    assign o_break      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uartrx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uartrx
// Purpose  : Self-checking bench for uartrx: an 8N1 instance and an 8E2
//            instance driven with directed and random frames.
// Revision : 1.0  initial release
// ============================================================================
module tb_uartrx;

    localparam int CLK_FRQ = 1_600_000;
    localparam int BAUD_R  = 100_000;
    localparam int BIT_CLK = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx1, rdy0, rdy1;
    logic [7:0] data0, data1;
    logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1, br0, br1, bz0, bz1;

    word_t obs0[$], obs1[$], exp0[$], exp1[$];
    int    n_ov0 = 0, n_ov1 = 0, n_br0 = 0, n_br1 = 0, exp_br0 = 0, exp_br1 = 0;
    int    cyc = 0, rise0 = -1;
    logic  v0_prev = 1'b0;
    int    asserts = 0, fails = 0;

    always #5 clk = ~clk;

    uartrx #(.I_CLK_FRQ(CLK_FRQ), .BAUD(BAUD_R), .PARITY(0), .FRAME(8), .STOP(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx0), .o_data(data0), .o_valid(v0),
        .i_ready(rdy0), .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun(ov0),
        .o_break(br0), .o_busy(bz0)
    );

    uartrx #(.I_CLK_FRQ(CLK_FRQ), .BAUD(BAUD_R), .PARITY(1), .FRAME(8), .STOP(2)) dut_p (
        .i_clk(clk), .i_rst(rst), .i_rx(rx1), .o_data(data1), .o_valid(v1),
        .i_ready(rdy1), .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1),
        .o_break(br1), .o_busy(bz1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0 && rdy0) obs0.push_back({data0, pe0, fe0});
        if (v1 && rdy1) obs1.push_back({data1, pe1, fe1});
        if (ov0) n_ov0++;
        if (ov1) n_ov1++;
        if (br0) n_br0++;
        if (br1) n_br1++;
        if (v0 && !v0_prev) rise0 = cyc;
        v0_prev = v0;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialise one frame; inst 1 carries a parity bit and two stop bits.
    task automatic send(input int inst, input logic [7:0] d, input logic pbit,
                        input logic [1:0] stops);
        logic b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (inst == 1) b.push_back(pbit);
        b.push_back(stops[0]);
        if (inst == 1) b.push_back(stops[1]);
        foreach (b[i]) begin
            if (inst == 0) rx0 = b[i]; else rx1 = b[i];
            repeat (BIT_CLK) @(posedge clk);
            #1;
        end
        if (inst == 0) rx0 = 1'b1; else rx1 = 1'b1;
    endtask

    // Reference: what a receiver must report for the frame that was put on the line.
    task automatic send_model(input int inst, input logic [7:0] d, input logic pbit,
                              input logic [1:0] stops);
        word_t w;
        logic  brk;
        w.d  = d;
        w.pe = (inst == 1) ? (pbit != ^d) : 1'b0;
        w.fe = (inst == 0) ? !stops[0] : !(stops[0] && stops[1]);
        brk  = 1'b0;
`ifdef UARTRX_BREAK_DETECT_EN
        brk  = (d == 8'h00) && (inst == 0 || pbit == 1'b0) && w.fe;
`endif
        if (brk) begin
            if (inst == 0) exp_br0++; else exp_br1++;
        end else begin
            if (inst == 0) exp0.push_back(w); else exp1.push_back(w);
        end
        send(inst, d, pbit, stops);
    endtask

    task automatic pop_pair(input int inst, output word_t o, output word_t e, output bit ok);
        ok = 1'b0;
        o  = '0;
        e  = '0;
        if (inst == 0 && obs0.size() > 0 && exp0.size() > 0) begin
            o = obs0.pop_front(); e = exp0.pop_front(); ok = 1'b1;
        end else if (inst == 1 && obs1.size() > 0 && exp1.size() > 0) begin
            o = obs1.pop_front(); e = exp1.pop_front(); ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
        idle(4);
        asserts++;
        if ({v0, data0, pe0, fe0, ov0, br0, bz0} !== 14'd0) begin
            fails++;
            $display("FAIL reset_dut0 got v=%b d=%h pe=%b fe=%b ov=%b br=%b bz=%b want all 0",
                     v0, data0, pe0, fe0, ov0, br0, bz0);
        end
        asserts++;
        if ({v1, data1, pe1, fe1, ov1, br1, bz1} !== 14'd0) begin
            fails++;
            $display("FAIL reset_dut1 got v=%b d=%h pe=%b fe=%b ov=%b br=%b bz=%b want all 0",
                     v1, data1, pe1, fe1, ov1, br1, bz1);
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_basic();
        int    t0;
        word_t o, e;
        bit    ok;
        t0 = cyc;
        send_model(0, 8'hA5, 1'b0, 2'b11);
        idle(4);
        asserts++;
        if (obs0.size() != 1) begin
            fails++;
            $display("FAIL basic_count got %0d words want 1", obs0.size());
        end
        pop_pair(0, o, e, ok);
        asserts++;
        if (!ok || o !== e) begin
            fails++;
            $display("FAIL basic_word got %h want %h", o, e);
        end
        asserts++;
        if (rise0 - t0 < 150 || rise0 - t0 > 160) begin
            fails++;
            $display("FAIL basic_latency got %0d clk want 150..160", rise0 - t0);
        end
        asserts++;
        if (v0 !== 1'b0) begin
            fails++;
            $display("FAIL basic_valid_drop got %b want 0", v0);
        end
        obs0.delete(); exp0.delete();
    endtask

    task automatic test_parity();
        word_t o, e;
        bit    ok;
        send_model(1, 8'h03, 1'b1, 2'b11);
        idle(4);
        send_model(1, 8'h07, 1'b1, 2'b11);
        idle(4);
        send_model(1, 8'h80, 1'b1, 2'b01);
        idle(8);
        asserts++;
        if (obs1.size() != exp1.size()) begin
            fails++;
            $display("FAIL parity_count got %0d want %0d", obs1.size(), exp1.size());
        end
        while (obs1.size() > 0 && exp1.size() > 0) begin
            pop_pair(1, o, e, ok);
            asserts++;
            if (o !== e) begin
                fails++;
                $display("FAIL parity_word got %h want %h", o, e);
            end
        end
        obs1.delete(); exp1.delete();
    endtask

    task automatic test_frame_err();
        word_t o, e;
        bit    ok;
        send_model(0, 8'h5A, 1'b0, 2'b10);
        idle(8);
        asserts++;
        if (obs0.size() != 1) begin
            fails++;
            $display("FAIL frame_count got %0d want 1", obs0.size());
        end
        pop_pair(0, o, e, ok);
        asserts++;
        if (!ok || o !== e) begin
            fails++;
            $display("FAIL frame_word got %h want %h", o, e);
        end
        obs0.delete(); exp0.delete();
    endtask

    task automatic test_false_start();
        int  t0, t_idle;
        bit  saw;
        saw    = 1'b0;
        t_idle = -1;
        t0     = cyc;
        rx0    = 1'b0;
        idle(5);
        rx0    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bz0) saw = 1'b1;
            if (saw && !bz0 && t_idle < 0) t_idle = cyc - t0;
        end
        asserts++;
        if (!saw || t_idle < 0 || t_idle > 16) begin
            fails++;
            $display("FAIL false_start_busy saw=%b back_idle_at=%0d want busy then idle by 16",
                     saw, t_idle);
        end
        asserts++;
        if (obs0.size() != 0 || v0 !== 1'b0) begin
            fails++;
            $display("FAIL false_start_output got %0d words v=%b want 0", obs0.size(), v0);
        end
    endtask

    task automatic test_overrun();
        int ov_base;
        rdy0 = 1'b0;
        send(0, 8'h11, 1'b0, 2'b11);
        idle(4);
        asserts++;
        if (v0 !== 1'b1 || data0 !== 8'h11) begin
            fails++;
            $display("FAIL overrun_first got v=%b d=%h want v=1 d=11", v0, data0);
        end
        ov_base = n_ov0;
        send(0, 8'h22, 1'b0, 2'b11);
        idle(4);
        asserts++;
        if (n_ov0 - ov_base != 1) begin
            fails++;
            $display("FAIL overrun_pulse got %0d pulses want 1", n_ov0 - ov_base);
        end
        asserts++;
        if (v0 !== 1'b1 || data0 !== 8'h11 || fe0 !== 1'b0) begin
            fails++;
            $display("FAIL overrun_hold got v=%b d=%h fe=%b want v=1 d=11 fe=0", v0, data0, fe0);
        end
        rdy0 = 1'b1;
        @(posedge clk); #1;
        asserts++;
        if (v0 !== 1'b0 || data0 !== 8'h11) begin
            fails++;
            $display("FAIL overrun_accept got v=%b d=%h want v=0 d=11", v0, data0);
        end
        asserts++;
        if (obs0.size() != 1 || obs0[0].d !== 8'h11) begin
            fails++;
            $display("FAIL overrun_handshakes got %0d words want 1 word 11", obs0.size());
        end
        obs0.delete(); exp0.delete();
    endtask

    task automatic test_reset_mid();
        word_t o, e;
        bit    ok;
        logic [7:0] d;
        d   = 8'h33;
        rx0 = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 3; i++) begin
            rx0 = d[i];
            idle(BIT_CLK);
        end
        asserts++;
        if (bz0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_busy_before got %b want 1", bz0);
        end
        rst = 1'b1;
        rx0 = 1'b1;
        idle(3);
        asserts++;
        if ({v0, data0, pe0, fe0, ov0, br0, bz0} !== 14'd0) begin
            fails++;
            $display("FAIL reset_mid_values got v=%b d=%h pe=%b fe=%b bz=%b want all 0",
                     v0, data0, pe0, fe0, bz0);
        end
        rst = 1'b0;
        idle(40);
        asserts++;
        if (obs0.size() != 0 || bz0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_quiet got %0d words bz=%b want 0 words bz=0", obs0.size(), bz0);
        end
        send_model(0, 8'h44, 1'b0, 2'b11);
        idle(6);
        pop_pair(0, o, e, ok);
        asserts++;
        if (!ok || o !== e) begin
            fails++;
            $display("FAIL reset_mid_next got %h want %h", o, e);
        end
        obs0.delete(); exp0.delete();
    endtask

    task automatic test_break();
        word_t o, e;
        bit    ok;
        int    br_base;
        br_base = n_br0;
        exp_br0 = 0;
        send_model(0, 8'h00, 1'b0, 2'b10);
        idle(4);
`ifdef UARTRX_BREAK_DETECT_EN
        asserts++;
        if (bz0 !== 1'b1) begin
            fails++;
            $display("FAIL break_rearm_busy got %b want 1", bz0);
        end
`endif
        asserts++;
        if (n_br0 - br_base != exp_br0) begin
            fails++;
            $display("FAIL break_pulse got %0d pulses want %0d", n_br0 - br_base, exp_br0);
        end
        idle(24);
        send_model(0, 8'h3C, 1'b0, 2'b11);
        idle(6);
        asserts++;
        if (obs0.size() != exp0.size()) begin
            fails++;
            $display("FAIL break_count got %0d want %0d", obs0.size(), exp0.size());
        end
        while (obs0.size() > 0 && exp0.size() > 0) begin
            pop_pair(0, o, e, ok);
            asserts++;
            if (o !== e) begin
                fails++;
                $display("FAIL break_word got %h want %h", o, e);
            end
        end
        obs0.delete(); exp0.delete();
    endtask

    task automatic test_random();
        word_t o, e;
        bit    ok;
        int    ov_base0, ov_base1;
        logic [1:0] st;
        ov_base0 = n_ov0;
        ov_base1 = n_ov1;
        for (int inst = 0; inst < 2; inst++) begin
            for (int k = 0; k < 12; k++) begin
                st[0] = ($urandom_range(0, 3) != 0);
                st[1] = ($urandom_range(0, 3) != 0);
                send_model(inst, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), st);
                if (inst == 0) rdy0 = 1'($urandom_range(0, 1));
                else           rdy1 = 1'($urandom_range(0, 1));
                idle($urandom_range(4, 20));
                rdy0 = 1'b1;
                rdy1 = 1'b1;
                idle(2);
            end
        end
        asserts++;
        if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
            fails++;
            $display("FAIL random_count got %0d/%0d want %0d/%0d",
                     obs0.size(), obs1.size(), exp0.size(), exp1.size());
        end
        for (int inst = 0; inst < 2; inst++) begin
            pop_pair(inst, o, e, ok);
            while (ok) begin
                asserts++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL random_word dut%0d got %h want %h", inst, o, e);
                end
                pop_pair(inst, o, e, ok);
            end
        end
        asserts++;
        if (n_ov0 != ov_base0 || n_ov1 != ov_base1 || n_br1 != 0) begin
            fails++;
            $display("FAIL random_flags got ov=%0d/%0d br1=%0d want no new pulses",
                     n_ov0 - ov_base0, n_ov1 - ov_base1, n_br1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_false_start();
        test_overrun();
        test_reset_mid();
        test_break();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
`default_nettype wire
